// File: rtl/dac_rate_sequencer.sv
// rtl/dac_rate_sequencer.sv - input/output rate strobe sequencer for the sigma-delta DAC interpolation chain
// Walks IDLE -> FLUSH -> PRIME -> RUN -> DRAIN and feeds one staged sample per frame to the FIR.
module dac_rate_sequencer #(
  parameter int unsigned BITLEN     = 16,
  parameter int unsigned OSR        = 256,
  parameter int unsigned CIC_STAGES = 3,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned UNDERRUN_W = 8,
  localparam int unsigned PH_W      = $clog2(OSR)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  run_i,
  input  logic [DIV_W-1:0]      div_out_i,
  input  logic                  hold_mode_i,
  input  logic [BITLEN-1:0]     s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [BITLEN-1:0]     sample_out_o,
  output logic                  in_ena_o,
  output logic                  out_ena_o,
  output logic [PH_W-1:0]       phase_o,
  output logic                  flush_o,
  output logic                  busy_o,
  output logic                  underrun_o,
  output logic [UNDERRUN_W-1:0] underrun_cnt_o
);

  localparam int unsigned        CNT_W       = $clog2(CIC_STAGES + 2);
  localparam logic [CNT_W-1:0]   STAGES_LAST = CNT_W'(CIC_STAGES);
  localparam logic [PH_W-1:0]    PH_LAST     = PH_W'(OSR - 1);

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_PRIME, S_RUN, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      stage_cnt_q, stage_cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [BITLEN-1:0]     sample_q, sample_d;
  logic [BITLEN-1:0]     buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;
  logic                  s_ready_q, s_ready_d;
  logic                  in_ena_q, in_ena_d;
  logic                  out_ena_q, out_ena_d;
  logic                  flush_q, flush_d;
  logic                  busy_q, busy_d;
  logic                  underrun_q, underrun_d;
  logic [UNDERRUN_W-1:0] urun_cnt_q, urun_cnt_d;

  logic handshake;
  logic div_wrap;
  logic boundary;

  assign handshake = s_valid_i & s_ready_q;
  assign div_wrap  = (div_cnt_q == div_q);
  // The edge that wraps the last phase of a frame begins the next frame's in_ena cycle.
  assign boundary  = div_wrap & (phase_q == PH_LAST);

  always_comb begin
    state_d     = state_q;
    stage_cnt_d = stage_cnt_q;
    div_d       = div_q;
    div_cnt_d   = div_cnt_q;
    phase_d     = phase_q;
    sample_d    = sample_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    in_ena_d    = 1'b0;
    out_ena_d   = 1'b0;
    underrun_d  = 1'b0;
    urun_cnt_d  = urun_cnt_q;

    case (state_q)
      S_IDLE: begin
        phase_d    = '0;
        sample_d   = '0;
        div_cnt_d  = '0;
        buf_full_d = 1'b0;
        if (run_i) begin
          state_d     = S_FLUSH;
          stage_cnt_d = '0;
          urun_cnt_d  = '0;
        end
      end

      S_FLUSH: begin
        if (stage_cnt_q == STAGES_LAST) begin
          state_d = S_PRIME;
          div_d   = div_out_i;
        end else begin
          stage_cnt_d = stage_cnt_q + CNT_W'(1);
        end
      end

      S_PRIME: begin
        if (handshake) begin
          state_d    = S_RUN;
          sample_d   = s_data_i;
          in_ena_d   = 1'b1;
          out_ena_d  = 1'b1;
          phase_d    = '0;
          div_cnt_d  = '0;
          buf_full_d = 1'b0;
        end else if (!run_i) begin
          state_d = S_IDLE;
        end
      end

      S_RUN, S_DRAIN: begin
        if (div_wrap) begin
          div_cnt_d = '0;
          out_ena_d = 1'b1;
          phase_d   = phase_q + PH_W'(1);
          in_ena_d  = boundary;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        if (state_q == S_RUN) begin
          if (!run_i) begin
            state_d     = S_DRAIN;
            buf_full_d  = 1'b0;
            stage_cnt_d = '0;
            if (boundary) begin
              sample_d    = '0;
              stage_cnt_d = CNT_W'(1);
            end
          end else if (boundary) begin
            if (buf_full_q) begin
              sample_d   = buf_q;
              buf_full_d = 1'b0;
            end else if (handshake) begin
              sample_d = s_data_i;
            end else begin
              underrun_d = 1'b1;
              if (!hold_mode_i) sample_d = '0;
              if (urun_cnt_q != {UNDERRUN_W{1'b1}}) urun_cnt_d = urun_cnt_q + UNDERRUN_W'(1);
            end
          end else if (handshake) begin
            buf_d      = s_data_i;
            buf_full_d = 1'b1;
          end
        end else begin
          // Leave right after the final out_ena of the last zero frame, not at the next divider wrap.
          if (out_ena_q && (phase_q == PH_LAST) && (stage_cnt_q == STAGES_LAST)) begin
            state_d   = S_IDLE;
            in_ena_d  = 1'b0;
            out_ena_d = 1'b0;
            phase_d   = '0;
            div_cnt_d = '0;
            sample_d  = '0;
          end else if (boundary) begin
            sample_d    = '0;
            stage_cnt_d = stage_cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    s_ready_d = (state_d == S_PRIME) || ((state_d == S_RUN) && !buf_full_d);
    flush_d   = (state_d == S_FLUSH);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      stage_cnt_q <= '0;
      div_q       <= '0;
      div_cnt_q   <= '0;
      phase_q     <= '0;
      sample_q    <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      s_ready_q   <= 1'b0;
      in_ena_q    <= 1'b0;
      out_ena_q   <= 1'b0;
      flush_q     <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
      urun_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      stage_cnt_q <= stage_cnt_d;
      div_q       <= div_d;
      div_cnt_q   <= div_cnt_d;
      phase_q     <= phase_d;
      sample_q    <= sample_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      s_ready_q   <= s_ready_d;
      in_ena_q    <= in_ena_d;
      out_ena_q   <= out_ena_d;
      flush_q     <= flush_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
      urun_cnt_q  <= urun_cnt_d;
    end
  end

  assign s_ready_o      = s_ready_q;
  assign sample_out_o   = sample_q;
  assign in_ena_o       = in_ena_q;
  assign out_ena_o      = out_ena_q;
  assign phase_o        = phase_q;
  assign flush_o        = flush_q;
  assign busy_o         = busy_q;
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = urun_cnt_q;

endmodule

// File: tb/tb_dac_rate_sequencer.sv
// tb/tb_dac_rate_sequencer.sv - self-checking bench for dac_rate_sequencer
// OSR=4, CIC_STAGES=3, div_out=2 (frame = 12 cycles), UNDERRUN_W=2.
module tb_dac_rate_sequencer;

  localparam int FRAME = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] div_out;
  logic        hold;
  logic [15:0] data;
  logic        valid;
  logic        s_ready_o;
  logic [15:0] sample_out_o;
  logic        in_ena_o;
  logic        out_ena_o;
  logic [1:0]  phase_o;
  logic        flush_o;
  logic        busy_o;
  logic        underrun_o;
  logic [1:0]  underrun_cnt_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dac_rate_sequencer #(
    .BITLEN(16), .OSR(4), .CIC_STAGES(3), .DIV_W(16), .UNDERRUN_W(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .div_out_i(div_out), .hold_mode_i(hold),
    .s_data_i(data), .s_valid_i(valid), .s_ready_o(s_ready_o), .sample_out_o(sample_out_o),
    .in_ena_o(in_ena_o), .out_ena_o(out_ena_o), .phase_o(phase_o), .flush_o(flush_o),
    .busy_o(busy_o), .underrun_o(underrun_o), .underrun_cnt_o(underrun_cnt_o)
  );

  // {flush, s_ready, in_ena, out_ena, busy, underrun, phase[1:0], sample[15:0], underrun_cnt[1:0]}
  function automatic logic [25:0] obs();
    return {flush_o, s_ready_o, in_ena_o, out_ena_o, busy_o, underrun_o, phase_o, sample_out_o, underrun_cnt_o};
  endfunction

  task automatic check_vec(input string name, input logic [25:0] act, input logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got fl/rdy/in/out/busy/ur=%b ph=%0d smp=%h ucnt=%0d, expected fl/rdy/in/out/busy/ur=%b ph=%0d smp=%h ucnt=%0d",
               name, act[25:20], act[19:18], act[17:2], act[1:0], exp[25:20], exp[19:18], exp[17:2], exp[1:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, start, wait for PRIME, hand over d; returns at the first RUN cycle (k=0).
  task automatic bring_up(input logic [15:0] d);
    bit got;
    run = 1'b0; valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    run = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = s_ready_o;
    end
    check_int("prime_ready", int'(got), 1);
    valid = 1'b1; data = d;
    tick();
    valid = 1'b0;
    check_int("first_frame", int'({in_ena_o, out_ena_o, sample_out_o}), int'({2'b11, d}));
  endtask

  typedef struct {
    logic        run;
    logic        valid;
    logic        hold;
    logic [15:0] data;
    logic [25:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic h, input logic [15:0] d,
                              input logic [5:0] fl6, input logic [1:0] ph, input logic [15:0] sm,
                              input logic [1:0] uc);
    vec_t t;
    t.run = r; t.valid = v; t.hold = h; t.data = d;
    t.exp = {fl6, ph, sm, uc};
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [18];
    int n;

    // fl6 = {flush, s_ready, in_ena, out_ena, busy, underrun}
    vt[0]  = mk(1, 0, 1, 16'h0000, 6'b100010, 2'd0, 16'h0000, 2'd0);
    vt[1]  = mk(1, 0, 1, 16'h0000, 6'b100010, 2'd0, 16'h0000, 2'd0);
    vt[2]  = mk(1, 0, 1, 16'h0000, 6'b100010, 2'd0, 16'h0000, 2'd0);
    vt[3]  = mk(1, 0, 1, 16'h0000, 6'b100010, 2'd0, 16'h0000, 2'd0);
    vt[4]  = mk(1, 0, 1, 16'h0000, 6'b010010, 2'd0, 16'h0000, 2'd0);
    vt[5]  = mk(1, 1, 1, 16'h1234, 6'b011110, 2'd0, 16'h1234, 2'd0);
    vt[6]  = mk(1, 0, 1, 16'h0000, 6'b010010, 2'd0, 16'h1234, 2'd0);
    vt[7]  = mk(1, 0, 1, 16'h0000, 6'b010010, 2'd0, 16'h1234, 2'd0);
    vt[8]  = mk(1, 0, 1, 16'h0000, 6'b010110, 2'd1, 16'h1234, 2'd0);
    vt[9]  = mk(1, 0, 1, 16'h0000, 6'b010010, 2'd1, 16'h1234, 2'd0);
    vt[10] = mk(1, 0, 1, 16'h0000, 6'b010010, 2'd1, 16'h1234, 2'd0);
    vt[11] = mk(1, 0, 1, 16'h0000, 6'b010110, 2'd2, 16'h1234, 2'd0);
    vt[12] = mk(1, 0, 1, 16'h0000, 6'b010010, 2'd2, 16'h1234, 2'd0);
    vt[13] = mk(1, 0, 1, 16'h0000, 6'b010010, 2'd2, 16'h1234, 2'd0);
    vt[14] = mk(1, 0, 1, 16'h0000, 6'b010110, 2'd3, 16'h1234, 2'd0);
    vt[15] = mk(1, 0, 1, 16'h0000, 6'b010010, 2'd3, 16'h1234, 2'd0);
    vt[16] = mk(1, 0, 1, 16'h0000, 6'b010010, 2'd3, 16'h1234, 2'd0);
    vt[17] = mk(1, 0, 1, 16'h0000, 6'b011111, 2'd0, 16'h1234, 2'd1);

    rst = 1'b1; run = 1'b0; div_out = 16'd2; hold = 1'b0; data = '0; valid = 1'b0;
    tick();
    check_vec("reset_state", obs(), 26'h0);
    tick();
    rst = 1'b0;
    tick();
    check_vec("idle_after_reset", obs(), 26'h0);

    // Start-up through the first underrun (hold_mode=1 repeats 0x1234)
    for (int i = 0; i < 18; i++) begin
      run = vt[i].run; valid = vt[i].valid; hold = vt[i].hold; data = vt[i].data;
      tick();
      check_vec($sformatf("startup_vec%0d", i), obs(), vt[i].exp);
    end
    valid = 1'b0;

    // Backpressure: 0x0002 waits in the buffer, 0x0003 accepted at the boundary
    hold = 1'b0;
    bring_up(16'h0001);
    check_int("bp_ready_k0", int'(s_ready_o), 1);
    valid = 1'b1; data = 16'h0002;
    tick();
    check_int("bp_buffered", int'(s_ready_o), 0);
    data = 16'h0003;
    n = 0;
    for (int k = 1; k < FRAME; k++) begin
      n += int'(s_ready_o);
      tick();
    end
    check_int("bp_ready_low_cycles", n, 0);
    check_int("bp_boundary", int'({in_ena_o, underrun_o, s_ready_o, sample_out_o}), int'({3'b101, 16'h0002}));
    tick();
    valid = 1'b0;
    check_int("bp_third_accepted", int'(s_ready_o), 0);
    for (int k = 13; k < 2 * FRAME; k++) tick();
    check_int("bp_second_boundary", int'({in_ena_o, underrun_o, sample_out_o}), int'({2'b10, 16'h0003}));

    // Underrun zero fill and saturation of the 2-bit counter
    hold = 1'b0;
    bring_up(16'h5555);
    n = 0;
    for (int k = 1; k <= 5 * FRAME; k++) begin
      tick();
      n += int'(underrun_o);
      if (k == FRAME)
        check_int("underrun_zero_fill", int'({in_ena_o, sample_out_o, underrun_o, underrun_cnt_o}),
                  int'({1'b1, 16'h0000, 1'b1, 2'd1}));
    end
    check_int("underrun_pulses", n, 5);
    check_int("underrun_saturated", int'(underrun_cnt_o), 3);

    // Asynchronous reset in the middle of a cycle
    #3;
    rst = 1'b1;
    #1;
    check_vec("async_reset_same_cycle", obs(), 26'h0);
    run = 1'b0;
    #3;
    rst = 1'b0;
    tick();
    check_vec("async_reset_idle", obs(), 26'h0);

    // Randomized runs against a frame/queue reference model, each ending in a stop and drain
    for (int r = 0; r < 3; r++) begin
      logic [15:0] q[$];
      logic [15:0] cur;
      logic [15:0] d0;
      logic [25:0] e;
      logic        urun;
      bit          running;
      int          ucnt, p, k_stop, k_last, zstart, f, oc, ic;

      hold = 1'($urandom_range(0, 1));
      p = $urandom_range(1, 6);
      d0 = 16'($urandom);
      bring_up(d0);
      cur = d0; urun = 1'b0; ucnt = 0; running = 1'b1; q.delete();
      k_last = 1 << 30; zstart = 1 << 30; oc = 0; ic = 0; f = 0;
      k_stop = FRAME * $urandom_range(3, 6) + ((r == 0) ? $urandom_range(3, 5) : $urandom_range(0, 11));

      for (int k = 0; k < 400; k++) begin
        if (k <= k_last)
          e = {1'b0, (running && q.size() == 0), (k % FRAME == 0), (k % 3 == 0), 1'b1, urun,
               2'((k / 3) % 4), cur, 2'(ucnt)};
        else
          e = {8'h00, 16'h0000, 2'(ucnt)};
        check_vec($sformatf("random_r%0d_k%0d", r, k), obs(), e);
        if (k >= zstart && k <= k_last) begin
          oc += int'(out_ena_o);
          ic += int'(in_ena_o);
        end
        if (k == k_last + 1) begin
          run = 1'b0; valid = 1'b0;
          tick();
          check_vec($sformatf("random_r%0d_idle_stays", r), obs(), e);
          break;
        end

        valid = ($urandom_range(0, 7) < p);
        data = 16'($urandom);
        if (running && k == k_stop) begin
          running = 1'b0;
          run = 1'b0;
          q.delete();
          f = k / FRAME;
          zstart = (f + 1) * FRAME;
          k_last = (f + 3) * FRAME + 9;
        end else if (!running) begin
          run = 1'($urandom_range(0, 1));
        end else if (valid && q.size() == 0) begin
          q.push_back(data);
        end

        urun = 1'b0;
        if ((k + 1) % FRAME == 0 && k + 1 <= k_last) begin
          if (!running) cur = 16'h0000;
          else if (q.size() > 0) cur = q.pop_front();
          else begin
            urun = 1'b1;
            if (!hold) cur = 16'h0000;
            if (ucnt < 3) ucnt++;
          end
        end
        tick();
      end
      check_int($sformatf("drain_out_ena_r%0d", r), oc, 12);
      check_int($sformatf("drain_in_ena_r%0d", r), ic, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_rate_sequencer.md
# dac_rate_sequencer

Rate controller for the sigma-delta DAC interpolation chain. Sits between the sample source and the FIR compensator / CIC interpolator / `sigdel_dac` path. Accepts input samples over a valid/ready handshake and generates two strobes: the input-rate strobe for the FIR and comb stages, and the output-rate strobe for the integrator stages. Also sequences start-up flush, steady-state run, underrun handling and shutdown drain, so the chain never consumes stale or partial data.

## Interface
- `BITLEN`, 16, sample width
- `OSR`, 256, output strobes per input sample; power of two, ≥2
- `CIC_STAGES`, 3, number of comb/integrator pairs; sets flush and drain length
- `DIV_W`, 16, width of the output-rate divider
- `UNDERRUN_W`, 8, width of the underrun counter
- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-high reset
- `run`  in  1  level; high = stream, low = stop after drain
- `div_out`  in  DIV_W  clocks per output strobe minus 1; latched on PRIME entry
- `hold_mode`  in  1  underrun fill: 0 = zero, 1 = repeat last sample
- `s_data`  in  BITLEN  upstream sample
- `s_valid`  in  1  upstream sample valid
- `s_ready`  out  1  sequencer can accept a sample
- `sample_out`  out  BITLEN  sample presented to the FIR
- `in_ena`  out  1  input-rate strobe (FIR, comb stages)
- `out_ena`  out  1  output-rate strobe (integrator stages)
- `phase`  out  $clog2(OSR)  index of the current `out_ena` within the frame
- `flush`  out  1  synchronous clear to FIR/CIC registers
- `busy`  out  1  state ≠ IDLE
- `underrun`  out  1  one-cycle pulse on underrun
- `underrun_cnt`  out  UNDERRUN_W  saturating underrun count

## Operation
- The FSM has five states: IDLE, FLUSH, PRIME, RUN, DRAIN. All outputs are registered.
- **IDLE:** all strobes low, `s_ready`=0. When `run`=1, go to FLUSH and clear `underrun_cnt`.
- **FLUSH:** `flush`=1 for exactly CIC_STAGES+1 cycles, then go to PRIME.
- **PRIME:**
  - `s_ready`=1 and `div_out` is latched on entry.
  - On a handshake (`s_valid`&`s_ready`), load `sample_out` and go to RUN.
  - If `run` falls here, return to IDLE.
- **RUN:**
  - The divider counts 0..div_q. `out_ena` pulses when it wraps, so the period is div_q+1 cycles (every cycle when div_q=0).
  - `phase` increments per `out_ena` and wraps OSR-1→0.
  - `in_ena` coincides with every `out_ena` whose `phase`=0 (frame boundary).
  - **Staging buffer:** one entry, with `s_ready`=!buf_full.
  - **Sample load at a frame boundary:** `sample_out` loads at the edge that begins the strobe cycle. The source is chosen in this priority:
    - buffer, if full (buffer then empties);
    - else a handshake on that same cycle (bypass);
    - else underrun: `sample_out` ← hold_mode ? `sample_out` : 0, `underrun` pulses, and `underrun_cnt` increments, saturating at all-ones.
  - A simultaneous boundary drain and new handshake is legal: the new sample enters the buffer.
- **run=0 in RUN:**
  - Go to DRAIN and drop `s_ready`.
  - The buffered sample is discarded.
  - The current frame completes with its sample.
- **DRAIN:**
  - Strobes continue for CIC_STAGES further frames with `sample_out`=0. No underrun is counted.
  - Then go to IDLE: `sample_out` stays 0 and `phase`=0.
  - `run` is ignored until IDLE is reached.
- **Reset:** asynchronous. The FSM returns to IDLE, and every output, counter and the buffer go to 0 immediately, including mid-frame.

## Timing
- The first RUN cycle, the cycle after the PRIME handshake, carries `in_ena`=`out_ena`=1, `phase`=0, and the new `sample_out`.
- `in_ena` period is (div_q+1)·OSR cycles. `in_ena` and `out_ena` are always one cycle wide.
- `underrun` is asserted in the same cycle as the boundary `in_ena`.
- `flush` is never asserted together with `in_ena` or `out_ena`.
- Changes to `div_out` during RUN/DRAIN have no effect.
- `busy` falls the cycle after the last drain `out_ena`.

## Test plan
Settings for all scenarios: OSR=4, CIC_STAGES=3, div_out=2.

- **Reset:** async `rst` mid-RUN → same-cycle outputs all 0, state IDLE, `underrun_cnt`=0.
- **Start-up:**
  - Stimulus: `run`=1, then `s_data`=0x1234 valid.
  - Required: `flush` high for 4 cycles, then `s_ready`=1.
  - Required, cycle after the handshake: `in_ena`=`out_ena`=1 and `sample_out`=0x1234.
  - Required, steady state: `out_ena` every 3 cycles, `in_ena` every 12 cycles.
- **Backpressure:**
  - Stimulus: source holds 0x0001, 0x0002, 0x0003 valid.
  - Required: 0x0002 is buffered and `s_ready`=0 until the next boundary. At that boundary `sample_out`=0x0002 and 0x0003 is accepted in the same cycle.
- **Underrun:**
  - Stimulus: no source data with hold_mode=0.
  - Required at the boundary: `sample_out`=0, `underrun` pulses, `underrun_cnt`=1.
  - With hold_mode=1: `sample_out` repeats 0x1234.
- **Saturation:** UNDERRUN_W=2 with 5 consecutive underruns → `underrun_cnt`=3.
- **Stop:**
  - Stimulus: `run`=0 at `phase`=1.
  - Required: the frame finishes, then 3 zero frames (12 `out_ena`, 3 `in_ena`). `busy` falls after that, and `run`=1 during DRAIN is ignored.
